hazard_sweep_ctrl: RTL and testbench



---
 rtl/hazard_sweep_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_sweep_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sweep_ctrl.sv
// Truth-table sweep sequencer comparing two 4-input function instances over all 16 vectors.
// Optional macro SWEEP_STOP_ON_FAIL_EN: halt the sweep at the first mismatching vector.
module hazard_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        f_a,
   input  logic        f_b,
   output logic [3:0]  vec_out,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  mismatch_cnt,
   output logic [15:0] mismatch_mask,
   output logic [3:0]  first_fail_vec,
   output logic        first_fail_valid
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned VEC_W  = 4;
   localparam int unsigned NVEC   = 16;
   localparam int unsigned MCNT_W = 5;
   localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);
   localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NVEC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    settle_q, settle_d;
   logic [VEC_W-1:0]    vec_q, vec_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [MCNT_W-1:0]   cnt_q, cnt_d;
   logic [NVEC-1:0]     mask_q, mask_d;
   logic [VEC_W-1:0]    ffv_q, ffv_d;
   logic                ffvalid_q, ffvalid_d;
   logic                mism_c;
   logic                clr_c;
   logic                launch_c;

   // State and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         settle_q  <= '0;
         vec_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         cnt_q     <= '0;
         mask_q    <= '0;
         ffv_q     <= '0;
         ffvalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         vec_q     <= vec_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         ffv_q     <= ffv_d;
         ffvalid_q <= ffvalid_d;
      end
   end

   // Next-state and result update
   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      vec_d     = vec_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      cnt_d     = cnt_q;
      mask_d    = mask_q;
      ffv_d     = ffv_q;
      ffvalid_d = ffvalid_q;
      mism_c    = f_a ^ f_b;
      clr_c     = 1'b0;
      launch_c  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               clr_c    = 1'b1;
               launch_c = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               clr_c = 1'b1;
            end else begin
               settle_d = settle_q - CNT_W'(1);
               if (settle_q <= CNT_W'(1)) begin
                  state_d = ST_SAMPLE;
               end
            end
         end
         ST_SAMPLE: begin
            if (abort) begin
               clr_c = 1'b1;
            end else begin
               if (mism_c) begin
                  mask_d[vec_q] = 1'b1;
                  cnt_d         = cnt_q + MCNT_W'(1);
                  if (!ffvalid_q) begin
                     ffv_d     = vec_q;
                     ffvalid_d = 1'b1;
                  end
               end
`ifdef SWEEP_STOP_ON_FAIL_EN
               if (mism_c || (vec_q == LAST_VEC)) begin
`else
               if (vec_q == LAST_VEC) begin
`endif
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (cnt_d == '0);
               end else begin
                  vec_d    = vec_q + VEC_W'(1);
                  settle_d = SETTLE_INIT;
                  state_d  = ST_SETTLE;
               end
            end
         end
         default: begin
            clr_c = 1'b1;
         end
      endcase

      // Abort, illegal state and restart all return every output to its reset value
      if (clr_c) begin
         state_d   = ST_IDLE;
         settle_d  = '0;
         vec_d     = '0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         pass_d    = 1'b0;
         cnt_d     = '0;
         mask_d    = '0;
         ffv_d     = '0;
         ffvalid_d = 1'b0;
      end

      if (launch_c) begin
         state_d  = ST_SETTLE;
         settle_d = SETTLE_INIT;
         busy_d   = 1'b1;
      end
   end

   assign vec_out          = vec_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign mismatch_cnt     = cnt_q;
   assign mismatch_mask    = mask_q;
   assign first_fail_vec   = ffv_q;
   assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_hazard_sweep_ctrl.sv
// Scoreboard bench for hazard_sweep_ctrl: random fault patterns, settle-time noise, abort and reset cases.
module tb_hazard_sweep_ctrl;

   localparam int N    = 4;
   localparam int HOLD = N + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        f_a;
   logic        f_b;
   logic [3:0]  vec_out;
   logic        busy, done, pass;
   logic [4:0]  mismatch_cnt;
   logic [15:0] mismatch_mask;
   logic [3:0]  first_fail_vec;
   logic        first_fail_valid;

   int          n_checks = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   logic [15:0] fault = '0;
   bit          noise_en = 1'b0;
   logic        noise_bit = 1'b0;
   logic        done_prev = 1'b0;

   typedef struct {
      int          lat;
      logic [4:0]  cnt;
      logic [15:0] mask;
      logic [3:0]  ffv;
      logic        ffvalid;
      logic        pass;
      logic [3:0]  vec;
   } exp_t;

   exp_t sb_q[$];

   hazard_sweep_ctrl #(.SETTLE_CYCLES(N)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .abort            (abort),
      .f_a              (f_a),
      .f_b              (f_b),
      .vec_out          (vec_out),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .mismatch_cnt     (mismatch_cnt),
      .mismatch_mask    (mismatch_mask),
      .first_fail_vec   (first_fail_vec),
      .first_fail_valid (first_fail_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) noise_bit <= 1'($urandom);

   // Function under test: a&c | b&~c&d | a&~b&~c; instance B is A with injected faults,
   // and random garbage outside the single sample cycle at the end of each vector hold.
   always_comb begin
      int t;
      f_a = (vec_out[0] & vec_out[2]) | (vec_out[1] & ~vec_out[2] & vec_out[3]) |
            (vec_out[0] & ~vec_out[1] & ~vec_out[2]);
      t = cyc - start_cyc;
      if (noise_en && (t % HOLD) != N) f_b = noise_bit;
      else                             f_b = f_a ^ fault[vec_out];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [15:0] flt);
      exp_t e;
      int   last;
      e.ffv = '0;
      for (int k = 15; k >= 0; k--) if (flt[k]) e.ffv = 4'(k);
      e.ffvalid = |flt;
      e.mask    = flt;
      e.cnt     = 5'($countones(flt));
      last      = 15;
`ifdef SWEEP_STOP_ON_FAIL_EN
      if (e.ffvalid) begin
         last   = int'(e.ffv);
         e.mask = 16'(1) << e.ffv;
         e.cnt  = 5'd1;
      end
`endif
      e.pass = (e.cnt == 5'd0);
      e.vec  = 4'(last);
      e.lat  = (last + 1) * HOLD;
      return e;
   endfunction

   // Monitor: every rising done is matched against the oldest expected sweep result
   always @(negedge clk) begin
      if (rst_n && done && !done_prev) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'(0));
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("latency",    32'(cyc - start_cyc), 32'(e.lat));
            check("pass",       32'(pass),             32'(e.pass));
            check("busy_done",  32'(busy),             32'(0));
            check("cnt",        32'(mismatch_cnt),     32'(e.cnt));
            check("mask",       32'(mismatch_mask),    32'(e.mask));
            check("ffvalid",    32'(first_fail_valid), 32'(e.ffvalid));
            check("ffv",        32'(first_fail_vec),   32'(e.ffv));
            check("vec_done",   32'(vec_out),          32'(e.vec));
         end
      end
      done_prev <= done;
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_vec"},     32'(vec_out),          32'(0));
      check({tag, "_busy"},    32'(busy),             32'(0));
      check({tag, "_done"},    32'(done),             32'(0));
      check({tag, "_pass"},    32'(pass),             32'(0));
      check({tag, "_cnt"},     32'(mismatch_cnt),     32'(0));
      check({tag, "_mask"},    32'(mismatch_mask),    32'(0));
      check({tag, "_ffv"},     32'(first_fail_vec),   32'(0));
      check({tag, "_ffvalid"}, 32'(first_fail_valid), 32'(0));
   endtask

   task automatic issue_sweep(input logic [15:0] flt, input bit noisy, input bit with_abort);
      @(negedge clk);
      noise_en = 1'b0;
      fault    = flt;
      sb_q.push_back(model(flt));
      start = 1'b1;
      abort = with_abort;
      @(posedge clk);
      #1;
      start     = 1'b0;
      abort     = 1'b0;
      start_cyc = cyc;
      noise_en  = noisy;
   endtask

   task automatic wait_done();
      int b = 0;
      while (sb_q.size() != 0 && b < 2000) begin
         @(posedge clk);
         b++;
      end
      if (sb_q.size() != 0) begin
         check("done_timeout", 32'(sb_q.size()), 32'(0));
         sb_q.delete();
      end
   endtask

   task automatic wait_vec(input logic [3:0] v);
      int b = 0;
      do begin
         @(negedge clk);
         b++;
      end while (vec_out != v && b < 2000);
      check("wait_vec", 32'(vec_out), 32'(v));
   endtask

   task automatic drop_sweep();
      sb_q.delete();
      noise_en = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("idle");

      // Identical functions, then the two-fault pattern
      issue_sweep(16'h0000, 1'b0, 1'b0);
      check("busy_after_start", 32'(busy), 32'(1));
      wait_done();
      repeat (3) @(negedge clk);
      check("done_holds", 32'(done), 32'(1));
      check("pass_holds", 32'(pass), 32'(1));
      issue_sweep(16'h1020, 1'b0, 1'b0);
      wait_done();

      // Random fault patterns, half of them with garbage on f_b while settling
      for (int i = 0; i < 6; i++) begin
         issue_sweep(16'($urandom) & 16'($urandom), 1'(i % 2), 1'b0);
         wait_done();
      end
      issue_sweep(16'h0000, 1'b1, 1'b0);
      wait_done();

      // Restart from DONE clears results on the capturing edge
      issue_sweep(16'h8000, 1'b0, 1'b0);
      check("restart_done_low", 32'(done), 32'(0));
      check("restart_mask_clr", 32'(mismatch_mask), 32'(0));
      check("restart_cnt_clr",  32'(mismatch_cnt), 32'(0));
      wait_done();

      // Abort while vector 7 is applied
      issue_sweep(16'h0000, 1'b0, 1'b0);
      wait_vec(4'd7);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      drop_sweep();
      check_all_zero("abort");

      // Abort and start together while busy: abort wins
      issue_sweep(16'h0000, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      drop_sweep();
      repeat (3) @(negedge clk);
      check_all_zero("abort_start");

      // Abort and start together in IDLE: start wins, sweep runs to completion
      issue_sweep(16'h0400, 1'b0, 1'b1);
      check("idle_start_wins", 32'(busy), 32'(1));
      wait_done();

      // Start while busy is ignored
      issue_sweep(16'($urandom) & 16'hFFF0, 1'b0, 1'b0);
      wait_vec(4'd3);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();

      // Asynchronous reset mid-sweep
      issue_sweep(16'h0000, 1'b0, 1'b0);
      wait_vec(4'd9);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      drop_sweep();
      @(negedge clk);
      rst_n = 1'b1;
      issue_sweep(16'h1020, 1'b0, 1'b0);
      wait_done();

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
